// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULTDIV_RADIX4_EN selects radix-4 Booth multiply (16 iterations) instead of radix-2 (32).
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

`ifdef MULTDIV_RADIX4_EN
    localparam int MULT_ITERS = 16;
    // Booth partial sums are signed and need one extra bit above the 32-bit upper half.
    localparam int HI_W       = 33;
`else
    localparam int MULT_ITERS = 32;
    localparam int HI_W       = 32;
`endif

    localparam int          DIV_ITERS = 32;
    localparam int          CNT_W     = 6;
    localparam logic [31:0] INT_MIN   = 32'h80000000;

    function automatic logic [31:0] abs32(input logic signed [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// 33-bit adder/subtractor: a 32-bit carry-lookahead adder plus one sign-extension bit.
// Shared by the multiply accumulate and the divide trial subtraction.
module cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [7:0]  w_gg;
    logic [7:0]  w_gp;
    logic [8:0]  w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Group generate/propagate for 4-bit blocks.
    always_comb begin
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < 8; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
    end

    always_comb begin
        logic c;
        c    = i_cin;
        w_gc = '0;
        for (int k = 0; k < 8; k++) begin
            w_gc[k] = c;
            c       = w_gg[k] | (w_gp[k] & c);
        end
        w_gc[8] = c;
    end

    always_comb begin
        w_c = '0;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[8];
endmodule

module multdiv_addsub (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    input  logic        i_sub,
    output logic [32:0] o_sum,
    output logic        o_cout
);
    logic [32:0] w_bx;
    logic        w_c32;

    assign w_bx = i_b ^ {33{i_sub}};

    cla32 u_cla (
        .i_a    (i_a[31:0]),
        .i_b    (w_bx[31:0]),
        .i_cin  (i_sub),
        .o_sum  (o_sum[31:0]),
        .o_cout (w_c32)
    );

    assign o_sum[32] = i_a[32] ^ w_bx[32] ^ w_c32;
    assign o_cout    = (i_a[32] & w_bx[32]) | ((i_a[32] ^ w_bx[32]) & w_c32);
endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide: magnitudes are iterated, sign and exceptions applied in FIX.
// Define MULTDIV_RADIX4_EN for the 16-iteration radix-4 Booth multiplier.
module multdiv
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_result;
    logic               r_exc;
    logic               r_rdy;

    logic [HI_W-1:0]    r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_opnd;
    logic               r_sign;
    logic               r_is_div;
    logic               r_dbz;
    logic               r_dovf;
`ifdef MULTDIV_RADIX4_EN
    logic               r_bprev;
    logic               r_bmsb;
    logic [33:0]        w_sum34;
    logic [31:0]        w_hi_fix;
`endif

    logic               w_start;
    logic               w_fire;
    logic [31:0]        w_absA;
    logic [31:0]        w_absB;
    logic [32:0]        w_as_a;
    logic [32:0]        w_as_b;
    logic               w_as_sub;
    logic [32:0]        w_as_sum;
    logic               w_as_cout;
    logic [63:0]        w_pmag;
    logic [63:0]        w_prod;
    logic               w_movf;
    logic [31:0]        w_quo;
    logic [31:0]        w_fix_res;
    logic               w_fix_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;
    // A strobe arriving in FIX aborts that result, so no RDY is issued for it.
    assign w_fire  = (r_state == FIX) && !w_start;
    assign w_absA  = abs32(data_operandA);
    assign w_absB  = abs32(data_operandB);

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ctrl_MULT ? MULT : DIV;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                MULT: if (r_cnt == CNT_W'(MULT_ITERS - 1)) w_state_nxt = FIX;
                DIV:  if (r_cnt == CNT_W'(DIV_ITERS - 1))  w_state_nxt = FIX;
                FIX:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rdy    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= w_fire;
            if (w_start) begin
                r_cnt <= '0;
            end else if (r_state == MULT || r_state == DIV) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fire) begin
                r_result <= w_fix_res;
                r_exc    <= w_fix_exc;
            end
        end
    end

    // Operand routing into the shared adder for the current iteration.
    always_comb begin
        w_as_a   = '0;
        w_as_b   = '0;
        w_as_sub = 1'b0;
        if (r_state == DIV) begin
            w_as_a   = {r_hi[31:0], r_lo[31]};
            w_as_b   = {1'b0, r_opnd};
            w_as_sub = 1'b1;
        end else begin
`ifdef MULTDIV_RADIX4_EN
            w_as_a = r_hi;
            case ({r_lo[1:0], r_bprev})
                3'b001, 3'b010: w_as_b = {1'b0, r_opnd};
                3'b011:         w_as_b = {r_opnd, 1'b0};
                3'b100: begin
                    w_as_b   = {r_opnd, 1'b0};
                    w_as_sub = 1'b1;
                end
                3'b101, 3'b110: begin
                    w_as_b   = {1'b0, r_opnd};
                    w_as_sub = 1'b1;
                end
                default:        w_as_b = '0;
            endcase
`else
            w_as_a = {1'b0, r_hi};
            w_as_b = r_lo[0] ? {1'b0, r_opnd} : 33'd0;
`endif
        end
    end

    multdiv_addsub u_addsub (
        .i_a    (w_as_a),
        .i_b    (w_as_b),
        .i_sub  (w_as_sub),
        .o_sum  (w_as_sum),
        .o_cout (w_as_cout)
    );

`ifdef MULTDIV_RADIX4_EN
    // Bit 33 of the signed sum: accumulator sign-extended, addend zero-extended then inverted on subtract.
    assign w_sum34  = {r_hi[32] ^ w_as_sub ^ w_as_cout, w_as_sum};
    // Booth reads a set bit 31 of the multiplier as -2^31; add back 2^32 * multiplicand.
    assign w_hi_fix = r_hi[31:0] + (r_bmsb ? r_opnd : 32'd0);
    assign w_pmag   = {w_hi_fix, r_lo};
`else
    assign w_pmag   = {r_hi, r_lo};
`endif

    always_ff @(posedge clock) begin
        if (w_start) begin
            r_opnd   <= ctrl_MULT ? w_absA : w_absB;
            r_lo     <= ctrl_MULT ? w_absB : w_absA;
            r_hi     <= '0;
            r_sign   <= data_operandA[31] ^ data_operandB[31];
            r_is_div <= !ctrl_MULT;
            r_dbz    <= (data_operandB == 32'd0);
            r_dovf   <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFFFFFF);
`ifdef MULTDIV_RADIX4_EN
            r_bprev  <= 1'b0;
            r_bmsb   <= w_absB[31];
`endif
        end else if (r_state == MULT) begin
`ifdef MULTDIV_RADIX4_EN
            r_hi    <= {w_sum34[33], w_sum34[33:2]};
            r_lo    <= {w_sum34[1:0], r_lo[31:2]};
            r_bprev <= r_lo[1];
`else
            r_hi <= w_as_sum[32:1];
            r_lo <= {w_as_sum[0], r_lo[31:1]};
`endif
        end else if (r_state == DIV) begin
            // No borrow means the trial remainder fits: keep it and record a quotient 1.
            r_hi[31:0] <= w_as_cout ? w_as_sum[31:0] : {r_hi[30:0], r_lo[31]};
            r_lo       <= {r_lo[30:0], w_as_cout};
        end
    end

    assign w_prod = r_sign ? neg64(w_pmag) : w_pmag;
    assign w_movf = !((&w_prod[63:31]) || !(|w_prod[63:31]));
    assign w_quo  = r_sign ? neg32(r_lo) : r_lo;

    always_comb begin
        w_fix_res = w_prod[31:0];
        w_fix_exc = w_movf;
        if (r_is_div) begin
            if (r_dbz) begin
                w_fix_res = 32'd0;
                w_fix_exc = 1'b1;
            end else if (r_dovf) begin
                w_fix_res = INT_MIN;
                w_fix_exc = 1'b1;
            end else begin
                w_fix_res = w_quo;
                w_fix_exc = 1'b0;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: arithmetic cases, exceptions, latency, abort and mid-operation reset.
module tb_multdiv;
    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks;
    int n_err;

`ifdef MULTDIV_RADIX4_EN
    localparam int MULT_LAT = 17;
`else
    localparam int MULT_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    multdiv dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc,
                          input int exp_lat, input string tag);
        int edges;
        bit seen;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = ~a;
        data_operandB = b ^ 32'h5A5A5A5A;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clock);
            #1;
            edges++;
            seen = data_resultRDY;
        end
        chk({tag, "_latency"}, edges, exp_lat);
        chk({tag, "_result"}, data_result, exp_res);
        chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        chk({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic count_rdy(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
    endtask

    initial begin
        int pulses;
        n_checks      = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op(1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, MULT_LAT, "mul_7_m3");
        run_op(1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, MULT_LAT, "mul_ovf");
        run_op(1'b0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, MULT_LAT, "mul_max");
        run_op(1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, MULT_LAT, "mul_intmin");
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, MULT_LAT, "mul_m1_m1");
        run_op(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, DIV_LAT,  "div_m7_2");
        run_op(1'b1, 32'd100,      32'd7,        32'h0000000E, 1'b0, DIV_LAT,  "div_100_7");
        run_op(1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1, DIV_LAT,  "div_by_zero");
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, DIV_LAT,  "div_intmin_m1");

        // Multiply 3 x 4, then a divide strobe ten cycles later must replace it.
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        run_op(1'b1, 32'd100, 32'd7, 32'h0000000E, 1'b0, DIV_LAT, "abort");
        count_rdy(40, pulses);
        chk("abort_no_extra_rdy", pulses, 0);

        // Reset sampled at iteration 12 of a divide drops it.
        @(negedge clock);
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (11) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exc", {31'd0, data_exception}, 32'd0);
        chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        count_rdy(40, pulses);
        chk("midreset_no_rdy", pulses, 0);
        run_op(1'b0, 32'd6, 32'd6, 32'h00000024, 1'b0, MULT_LAT, "mul_6_6");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
